neuron_simd: RTL and testbench

NEURON_SIMD -- requirements
Module: neuron_simd

---
 rtl/neuron_simd.sv | 196 +++++++++++++++++++
 tb/tb_neuron_simd.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_simd.sv
// neuron_simd: one fully connected neuron that streams LANES inputs per beat
// against an internal weight RAM, adds a bias and applies ReLU.
// Optional feature: define NEURON_SAT_EN for saturating accumulator/bias adds.
`timescale 1ns/1ps
module neuron_simd #(
  parameter int LAYER_NO     = 1,
  parameter int NEURON_NO    = 0,
  parameter int NUM_WEIGHT   = 784,
  parameter int DATA_WIDTH   = 16,
  parameter int LANES        = 4,
  parameter int WEIGHT_INT_W = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          weight_valid,
  input  logic [31:0]                   weight_value,
  input  logic                          bias_valid,
  input  logic [31:0]                   bias_value,
  input  logic [31:0]                   config_layer_num,
  input  logic [31:0]                   config_neuron_num,
  input  logic [LANES*DATA_WIDTH-1:0]   in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_valid,
  input  logic                          out_ready
);

  localparam int unsigned DW    = DATA_WIDTH;
  localparam int unsigned BEATS = NUM_WEIGHT / LANES;
  localparam int unsigned P_W   = 2 * DW;
  localparam int unsigned LW    = (LANES > 1) ? $clog2(LANES) : 0;
  localparam int unsigned S_W   = P_W + LW;
  localparam int unsigned AW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned LAW   = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned IW    = WEIGHT_INT_W;

  // Weights must tile the lanes exactly
  generate
    if ((NUM_WEIGHT % LANES) != 0) begin : g_bad_cfg
      $error("neuron_simd: NUM_WEIGHT must be a multiple of LANES");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, BIAS, ACT, HOLD} state_t;

  state_t                 state, next_state;
  logic                   sel, fire, last_beat;
  logic                   in_ready_d, out_valid_d;
  logic [AW-1:0]          beat_cnt;
  logic [AW-1:0]          widx;
  logic [LAW-1:0]         wlane;
  logic [DW-1:0]          bias_pend, bias_cur;
  logic                   v1, v2;
  logic [LANES*DW-1:0]    ram [BEATS];
  logic [LANES*DW-1:0]    rd_q, in_q;
  logic signed [P_W-1:0]  prod [LANES];
  logic signed [S_W-1:0]  sum_c, sum_q;
  logic signed [P_W-1:0]  acc;
  logic signed [P_W-1:0]  bias_term;
  logic [DW-1:0]          act_c, act_q;
  logic                   unused_hi;

  assign unused_hi = ^{weight_value[31:DW], bias_value[31:DW]};
  assign sel       = (config_layer_num == 32'(LAYER_NO)) && (config_neuron_num == 32'(NEURON_NO));
  assign fire      = in_valid && in_ready;
  assign last_beat = (beat_cnt == AW'(BEATS - 1));
  assign bias_term = $signed({bias_cur, {DW{1'b0}}});

  // Accumulator/bias addition: wraps by default, saturates when enabled
  function automatic logic signed [P_W-1:0] acc_add(input logic signed [P_W-1:0] a,
                                                    input logic signed [S_W-1:0] b);
`ifdef NEURON_SAT_EN
    logic signed [S_W:0] w;
    w = (S_W+1)'(a) + (S_W+1)'(b);
    if ((w[S_W:P_W-1] == '0) || (w[S_W:P_W-1] == '1))
      acc_add = w[P_W-1:0];
    else if (w[S_W])
      acc_add = {1'b1, {(P_W-1){1'b0}}};
    else
      acc_add = {1'b0, {(P_W-1){1'b1}}};
`else
    acc_add = P_W'(S_W'(a) + b);
`endif
  endfunction

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (fire) next_state = last_beat ? DRAIN : ACCUM;
      ACCUM: if (fire && last_beat) next_state = DRAIN;
      DRAIN: if (!v1 && !v2) next_state = BIAS;
      BIAS:  next_state = ACT;
      ACT:   next_state = HOLD;
      HOLD:  if (out_valid && out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode: ready only while collecting beats, valid held until taken
  always_comb begin
    in_ready_d  = (next_state == IDLE) || (next_state == ACCUM);
    out_valid_d = out_valid;
    if (state == HOLD && !out_valid) out_valid_d = 1'b1;
    if (out_valid && out_ready)      out_valid_d = 1'b0;
  end

  // Registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      if (state == HOLD && !out_valid) out_data <= act_q;
    end
  end

  // Weight RAM write and registered read alongside the input beat
  always_ff @(posedge clk) begin
    if (state == IDLE && weight_valid && sel)
      ram[widx][wlane*DW +: DW] <= weight_value[DW-1:0];
    if (fire) begin
      rd_q <= ram[beat_cnt];
      in_q <= in_data;
    end
  end

  // Per-lane signed products and lane-sum tree (widened so lanes never wrap)
  always_comb begin
    sum_c = '0;
    for (int l = 0; l < LANES; l++) begin
      prod[l] = P_W'($signed(in_q[l*DW +: DW])) * P_W'($signed(rd_q[l*DW +: DW]));
      sum_c   = sum_c + S_W'(prod[l]);
    end
  end

  // ReLU with clamp when the integer part exceeds the output format
  always_comb begin
    if (acc[P_W-1])
      act_c = '0;
    else if (|acc[P_W-1 -: IW+1])
      act_c = {1'b0, {(DW-1){1'b1}}};
    else
      act_c = acc[P_W-1-IW -: DW];
  end

  // Control counters, bias registers, pipeline valids and accumulator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt  <= '0;
      widx      <= '0;
      wlane     <= '0;
      bias_pend <= '0;
      bias_cur  <= '0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      sum_q     <= '0;
      acc       <= '0;
      act_q     <= '0;
    end else begin
      if (state == IDLE && weight_valid && sel) begin
        if (wlane == LAW'(LANES - 1)) begin
          wlane <= '0;
          widx  <= (widx == AW'(BEATS - 1)) ? '0 : widx + AW'(1);
        end else begin
          wlane <= wlane + LAW'(1);
        end
      end
      if (bias_valid && sel) bias_pend <= bias_value[DW-1:0];
      if (fire) beat_cnt <= last_beat ? '0 : beat_cnt + AW'(1);
      v1 <= fire;
      v2 <= v1;
      if (v1) sum_q <= sum_c;
      if (state == IDLE && fire) begin
        acc      <= '0;
        bias_cur <= bias_pend;
      end else if (v2) begin
        acc <= acc_add(acc, sum_q);
      end else if (state == BIAS) begin
        acc <= acc_add(acc, S_W'(bias_term));
      end
      if (state == ACT) act_q <= act_c;
    end
  end

endmodule

// File: tb/tb_neuron_simd.sv
// Directed self-checking bench for neuron_simd (LANES=4, NUM_WEIGHT=8).
`timescale 1ns/1ps
module tb_neuron_simd;

  logic        clk = 1'b0;
  logic        rst;
  logic        weight_valid, bias_valid, in_valid, out_ready;
  logic [31:0] weight_value, bias_value, config_layer_num, config_neuron_num;
  logic [63:0] in_data;
  logic        in_ready, out_valid;
  logic [15:0] out_data;

  int passed = 0;
  int total  = 0;

  localparam logic [63:0] PAT_A   = 64'h0000_0000_0000_4000;
  localparam logic [63:0] PAT_NEG = 64'hC000_C000_C000_C000;
  localparam logic [63:0] PAT_MIX = 64'h1000_E000_4000_2000;
  localparam logic [63:0] PAT_MAX = 64'h7FFF_7FFF_7FFF_7FFF;

  neuron_simd #(
    .LAYER_NO(1), .NEURON_NO(0), .NUM_WEIGHT(8), .DATA_WIDTH(16), .LANES(4), .WEIGHT_INT_W(1)
  ) dut (
    .clk(clk), .rst(rst),
    .weight_valid(weight_valid), .weight_value(weight_value),
    .bias_valid(bias_valid), .bias_value(bias_value),
    .config_layer_num(config_layer_num), .config_neuron_num(config_neuron_num),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic load_weights(input logic [15:0] w, input int n);
    config_layer_num = 1; config_neuron_num = 0;
    weight_valid = 1'b1; weight_value = {16'h0, w};
    repeat (n) @(negedge clk);
    weight_valid = 1'b0;
  endtask

  task automatic load_bias(input logic [15:0] b, input int layer, input int neuron);
    config_layer_num = 32'(layer); config_neuron_num = 32'(neuron);
    bias_valid = 1'b1; bias_value = {16'h0, b};
    @(negedge clk);
    bias_valid = 1'b0;
    config_layer_num = 1; config_neuron_num = 0;
  endtask

  task automatic send_beat(input logic [63:0] d, output bit ok);
    ok = 1'b0; in_valid = 1'b1; in_data = d;
    for (int i = 0; i < 30; i++) begin
      if (in_ready) begin
        @(posedge clk); ok = 1'b1; break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_vec(input logic [63:0] b0, input logic [63:0] b1, input int gap,
                         output int lat, output bit ok);
    bit ok0, ok1;
    send_beat(b0, ok0);
    repeat (gap) @(negedge clk);
    send_beat(b1, ok1);
    ok  = ok0 && ok1;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk); lat++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({in_ready, out_valid, out_data} !== 18'h0)
      $display("FAIL reset_outputs: got rdy=%b vld=%b data=%h want 0 0 0000", in_ready, out_valid, out_data);
    else passed++;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", in_ready);
    else passed++;
  endtask

  task automatic test_basic();
    int lat; bit ok;
    load_weights(16'h4000, 8);
    run_vec(PAT_A, PAT_A, 0, lat, ok);
    total++;
    if (!ok || lat != 6) $display("FAIL basic_latency: got ok=%0b lat=%0d want 1 6", ok, lat);
    else passed++;
    total++;
    if (out_data !== 16'h4000) $display("FAIL basic_data: got %h want 4000", out_data);
    else passed++;
    handshake();
    total++;
    if (out_valid !== 1'b0) $display("FAIL basic_valid_drop: got %b want 0", out_valid);
    else passed++;
  endtask

  task automatic test_relu();
    int lat; bit ok;
    run_vec(PAT_NEG, PAT_NEG, 0, lat, ok);
    total++;
    if (!ok || lat != 6 || out_data !== 16'h0000)
      $display("FAIL relu_negative: got lat=%0d data=%h want 6 0000", lat, out_data);
    else passed++;
    handshake();
  endtask

  task automatic test_stall();
    int lat; bit ok;
    run_vec(PAT_MIX, PAT_A, 3, lat, ok);
    total++;
    if (!ok || lat != 6) $display("FAIL stall_latency: got ok=%0b lat=%0d want 1 6", ok, lat);
    else passed++;
    total++;
    if (out_data !== 16'h4800) $display("FAIL stall_data: got %h want 4800", out_data);
    else passed++;
    handshake();
  endtask

  task automatic test_bias();
    int lat; bit ok;
    load_bias(16'h1000, 1, 0);
    load_bias(16'h7000, 1, 5);
    load_bias(16'h7000, 2, 0);
    run_vec(64'h0, 64'h0, 0, lat, ok);
    total++;
    if (!ok || lat != 6 || out_data !== 16'h2000)
      $display("FAIL bias_add: got lat=%0d data=%h want 6 2000", lat, out_data);
    else passed++;
    handshake();
    load_bias(16'h4000, 1, 0);
    run_vec(PAT_A, PAT_A, 0, lat, ok);
    total++;
    if (!ok || out_data !== 16'h7FFF) $display("FAIL bias_clamp: got %h want 7fff", out_data);
    else passed++;
    handshake();
    load_bias(16'h0000, 1, 0);
  endtask

  task automatic test_saturation();
    int lat; bit ok;
    logic [15:0] exp;
`ifdef NEURON_SAT_EN
    exp = 16'h7FFF;
`else
    exp = 16'h0000;
`endif
    load_weights(16'h7FFF, 8);
    run_vec(PAT_MAX, PAT_MAX, 0, lat, ok);
    total++;
    if (!ok || lat != 6 || out_data !== exp)
      $display("FAIL saturation: got lat=%0d data=%h want 6 %h", lat, out_data, exp);
    else passed++;
    handshake();
    load_weights(16'h4000, 8);
  endtask

  task automatic test_back_to_back();
    int lat; bit ok, ok0, ok1; int bad;
    run_vec(PAT_A, PAT_A, 0, lat, ok);
    total++;
    if (!ok || lat != 6 || out_data !== 16'h4000)
      $display("FAIL hold_first: got lat=%0d data=%h want 6 4000", lat, out_data);
    else passed++;
    in_valid = 1'b1; in_data = PAT_A;
    weight_valid = 1'b1; weight_value = 32'h0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if ({out_valid, out_data, in_ready} !== {1'b1, 16'h4000, 1'b0}) bad++;
    end
    weight_valid = 1'b0;
    total++;
    if (bad != 0) $display("FAIL hold_stable: got %0d bad cycles want 0", bad);
    else passed++;
    handshake();
    total++;
    if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL hold_release: got vld=%b rdy=%b want 0 1", out_valid, in_ready);
    else passed++;
    send_beat(PAT_A, ok0);
    send_beat(PAT_A, ok1);
    total++;
    if (in_ready !== 1'b0) $display("FAIL drain_not_ready: got %b want 0", in_ready);
    else passed++;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk); lat++;
    end
    total++;
    if (!(ok0 && ok1) || lat != 6 || out_data !== 16'h4000)
      $display("FAIL hold_second: got lat=%0d data=%h want 6 4000", lat, out_data);
    else passed++;
    handshake();
  endtask

  task automatic test_reset_mid();
    int lat; bit ok; int seen;
    send_beat(PAT_A, ok);
    rst = 1'b1;
    #1;
    total++;
    if ({in_ready, out_valid, out_data} !== 18'h0)
      $display("FAIL midreset_outputs: got rdy=%b vld=%b data=%h want 0 0 0000", in_ready, out_valid, out_data);
    else passed++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    total++;
    if (seen != 0) $display("FAIL midreset_no_output: got %0d valid cycles want 0", seen);
    else passed++;
    run_vec(PAT_A, PAT_A, 0, lat, ok);
    total++;
    if (!ok || lat != 6 || out_data !== 16'h4000)
      $display("FAIL midreset_fresh: got lat=%0d data=%h want 6 4000", lat, out_data);
    else passed++;
    handshake();
  endtask

  initial begin
    rst = 1'b1;
    weight_valid = 1'b0; weight_value = '0;
    bias_valid = 1'b0; bias_value = '0;
    config_layer_num = 1; config_neuron_num = 0;
    in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    test_reset();
    test_basic();
    test_relu();
    test_stall();
    test_bias();
    test_saturation();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
